// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
// Pulled in by prod_accum and acc_add.
package prod_accum_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/prod_accum_acc_add.sv
// Adds a 16-bit product into a W-bit running sum and reports the carry-out.
// Defining PROD_ACCUM_SAT_EN clamps the sum to all-ones on carry; otherwise it wraps.
module acc_add
    import prod_accum_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [15:0]  b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] raw;

    assign raw   = {1'b0, a} + {{(W-15){1'b0}}, b};
    assign carry = raw[W];

`ifdef PROD_ACCUM_SAT_EN
    // Once clamped, later beats keep carrying out, so the sum stays pinned at max.
    assign sum = raw[W] ? '1 : raw[W-1:0];
`else
    assign sum = raw[W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Accumulates a stream of prod8 products into one sum/count/overflow result per group.
// Sum saturation instead of wrap is selected with PROD_ACCUM_SAT_EN (inside acc_add).
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] sum_add;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             carry;
    logic             accept;
    logic             release_res;

    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;

    acc_add #(
        .W(ACC_W)
    ) u_acc_add (
        .a    (sum),
        .b    (in_data),
        .sum  (sum_add),
        .carry(carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:  if (accept && in_last) state_nxt = HOLD;
            HOLD: if (out_ready)         state_nxt = ACC;
        endcase
    end

    // Handshake flags depend only on the registered state.
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == HOLD);
    end

    // The result handshake clears the datapath so the next group starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (release_res) begin
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            sum   <= sum_add;
            count <= (count == CNT_MAX) ? count : count + CNT_W'(1);
            ovf   <= ovf | carry | (count == CNT_MAX);
        end
    end

    assign out_sum   = sum;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: three instances (default, ACC_W=17, CNT_W=2)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_prod_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [23:0] out_sum0;
    logic [16:0] out_sum1;
    logic [23:0] out_sum2;
    logic [7:0]  out_count0;
    logic [7:0]  out_count1;
    logic [1:0]  out_count2;
    logic        out_ovf0, out_ovf1, out_ovf2;

    logic [5:0]  obs_hs;
    logic [85:0] obs_all;

    int   n_cmp = 0;
    int   n_fail = 0;
    logic m_hold;
    logic dummy;

    assign obs_hs  = {in_ready0, in_ready1, in_ready2, out_valid0, out_valid1, out_valid2};
    assign obs_all = {out_sum0, out_count0, out_ovf0,
                      out_sum1, out_count1, out_ovf1,
                      out_sum2, out_count2, out_ovf2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prod_accum #(.ACC_W(24), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_sum(out_sum0), .out_count(out_count0), .out_ovf(out_ovf0)
    );

    prod_accum #(.ACC_W(17), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sum(out_sum1), .out_count(out_count1), .out_ovf(out_ovf1)
    );

    prod_accum #(.ACC_W(24), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2)
    );

    // Reference result of a group from its exact total and beat count.
    function automatic longint e_sum(longint total, int w);
        longint maxv;
        maxv = (longint'(1) << w) - 1;
`ifdef PROD_ACCUM_SAT_EN
        return (total > maxv) ? maxv : total;
`else
        return total & maxv;
`endif
    endfunction

    function automatic int e_cnt(int beats, int cw);
        int maxc;
        maxc = (1 << cw) - 1;
        return (beats > maxc) ? maxc : beats;
    endfunction

    function automatic logic e_ovf(longint total, int beats, int w, int cw);
        return (total > ((longint'(1) << w) - 1)) || (beats > ((1 << cw) - 1));
    endfunction

    function automatic logic [85:0] exp_all(longint total, int beats);
        return {24'(e_sum(total, 24)), 8'(e_cnt(beats, 8)), e_ovf(total, beats, 24, 8),
                17'(e_sum(total, 17)), 8'(e_cnt(beats, 8)), e_ovf(total, beats, 17, 8),
                24'(e_sum(total, 24)), 2'(e_cnt(beats, 2)), e_ovf(total, beats, 24, 2)};
    endfunction

    function automatic logic [5:0] exp_hs(logic hold);
        return {{3{~hold}}, {3{hold}}};
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic l,
                                 input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    // Advance one clock and update the handshake model; reports whether a beat was taken.
    task automatic tick(output logic accepted);
        logic done;
        accepted = in_valid && !m_hold;
        done     = m_hold && out_ready;
        @(posedge clk);
        if (accepted && in_last) m_hold = 1'b1;
        else if (done)           m_hold = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs_hs !== exp_hs(1'b0)) begin
            n_fail++;
            $display("[TB] FAIL reset_hs: got %b expected %b", obs_hs, exp_hs(1'b0));
        end
        n_cmp++;
        if (obs_all !== exp_all(0, 0)) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected %h", obs_all, exp_all(0, 0));
        end
        applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs_hs !== exp_hs(1'b0) || obs_all !== exp_all(0, 0)) begin
            n_fail++;
            $display("[TB] FAIL reset_held: got %b/%h expected %b/%h",
                     obs_hs, obs_all, exp_hs(1'b0), exp_all(0, 0));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] vals [3];
        longint      total;
        vals  = '{16'h0010, 16'h0020, 16'h0030};
        total = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, vals[i], (i == 2), 1'b1);
            n_cmp++;
            if (obs_hs !== exp_hs(1'b0)) begin
                n_fail++;
                $display("[TB] FAIL basic_ready_%0d: got %b expected %b", i, obs_hs, exp_hs(1'b0));
            end
            tick(dummy);
            total += vals[i];
            n_cmp++;
            if (obs_all !== exp_all(total, i + 1)) begin
                n_fail++;
                $display("[TB] FAIL basic_beat_%0d: got %h expected %h",
                         i, obs_all, exp_all(total, i + 1));
            end
        end
        n_cmp++;
        if (obs_hs !== exp_hs(1'b1) || out_sum0 !== 24'h60 || out_count0 !== 8'd3) begin
            n_fail++;
            $display("[TB] FAIL basic_result: got hs=%b sum=%h cnt=%0d expected hs=%b sum=60 cnt=3",
                     obs_hs, out_sum0, out_count0, exp_hs(1'b1));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick(dummy);
        n_cmp++;
        if (obs_hs !== exp_hs(1'b0) || obs_all !== exp_all(0, 0)) begin
            n_fail++;
            $display("[TB] FAIL basic_release: got %b/%h expected %b/%h",
                     obs_hs, obs_all, exp_hs(1'b0), exp_all(0, 0));
        end
    endtask

    task automatic test_hold();
        applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
        tick(dummy);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
            n_cmp++;
            if (obs_hs !== exp_hs(1'b1) || obs_all !== exp_all(64'hFFFF, 1)) begin
                n_fail++;
                $display("[TB] FAIL hold_stable_%0d: got %b/%h expected %b/%h",
                         i, obs_hs, obs_all, exp_hs(1'b1), exp_all(64'hFFFF, 1));
            end
            tick(dummy);
        end
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1);
        tick(dummy);
        n_cmp++;
        if (obs_hs !== exp_hs(1'b0) || obs_all !== exp_all(0, 0)) begin
            n_fail++;
            $display("[TB] FAIL hold_release: got %b/%h expected %b/%h",
                     obs_hs, obs_all, exp_hs(1'b0), exp_all(0, 0));
        end
        tick(dummy);
        n_cmp++;
        if (obs_hs !== exp_hs(1'b1) || obs_all !== exp_all(64'h1234, 1)) begin
            n_fail++;
            $display("[TB] FAIL hold_next_beat: got %b/%h expected %b/%h",
                     obs_hs, obs_all, exp_hs(1'b1), exp_all(64'h1234, 1));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick(dummy);
    endtask

    task automatic test_overflow();
        logic [16:0] want_sum1;
`ifdef PROD_ACCUM_SAT_EN
        want_sum1 = 17'h1FFFF;
`else
        want_sum1 = 17'h0FFFD;
`endif
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hFFFF, (i == 2), 1'b0);
            tick(dummy);
        end
        n_cmp++;
        if (out_sum1 !== want_sum1 || out_ovf1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_sum17: got sum=%h ovf=%b expected sum=%h ovf=1",
                     out_sum1, out_ovf1, want_sum1);
        end
        n_cmp++;
        if (obs_all !== exp_all(3 * 64'hFFFF, 3)) begin
            n_fail++;
            $display("[TB] FAIL ovf_all: got %h expected %h", obs_all, exp_all(3 * 64'hFFFF, 3));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick(dummy);
        n_cmp++;
        if (obs_all !== exp_all(0, 0)) begin
            n_fail++;
            $display("[TB] FAIL ovf_cleared: got %h expected %h", obs_all, exp_all(0, 0));
        end
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0001, (i == 3), 1'b0);
            tick(dummy);
        end
        n_cmp++;
        if (out_count2 !== 2'd3 || out_ovf2 !== 1'b1 || out_sum2 !== 24'd4) begin
            n_fail++;
            $display("[TB] FAIL cnt_sat: got cnt=%0d ovf=%b sum=%0d expected cnt=3 ovf=1 sum=4",
                     out_count2, out_ovf2, out_sum2);
        end
        n_cmp++;
        if (obs_all !== exp_all(4, 4)) begin
            n_fail++;
            $display("[TB] FAIL cnt_all: got %h expected %h", obs_all, exp_all(4, 4));
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        tick(dummy);
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
        tick(dummy);
        applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0);
        tick(dummy);
        n_cmp++;
        if (obs_all !== exp_all(64'h300, 2)) begin
            n_fail++;
            $display("[TB] FAIL mid_partial: got %h expected %h", obs_all, exp_all(64'h300, 2));
        end
        rst_n  = 1'b0;
        m_hold = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (obs_hs !== exp_hs(1'b0) || obs_all !== exp_all(0, 0)) begin
            n_fail++;
            $display("[TB] FAIL mid_async: got %b/%h expected %b/%h",
                     obs_hs, obs_all, exp_hs(1'b0), exp_all(0, 0));
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(dummy);
            n_cmp++;
            if (obs_hs !== exp_hs(1'b0)) begin
                n_fail++;
                $display("[TB] FAIL mid_no_valid_%0d: got %b expected %b", i, obs_hs, exp_hs(1'b0));
            end
        end
        applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0);
        tick(dummy);
        n_cmp++;
        if (obs_hs !== exp_hs(1'b1) || obs_all !== exp_all(5, 1)) begin
            n_fail++;
            $display("[TB] FAIL mid_next_group: got %b/%h expected %b/%h",
                     obs_hs, obs_all, exp_hs(1'b1), exp_all(5, 1));
        end
        rst_n  = 1'b0;
        m_hold = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
        #2;
        n_cmp++;
        if (obs_hs !== exp_hs(1'b0) || obs_all !== exp_all(0, 0)) begin
            n_fail++;
            $display("[TB] FAIL hold_reset: got %b/%h expected %b/%h",
                     obs_hs, obs_all, exp_hs(1'b0), exp_all(0, 0));
        end
        rst_n = 1'b1;
        tick(dummy);
        n_cmp++;
        if (obs_hs !== exp_hs(1'b0)) begin
            n_fail++;
            $display("[TB] FAIL hold_reset_after: got %b expected %b", obs_hs, exp_hs(1'b0));
        end
    endtask

    // Random groups with random valid gaps and output back-pressure; the upstream
    // keeps presenting a beat until it is taken, and junk is offered while in HOLD.
    task automatic test_back_to_back_random();
        logic [15:0] beats [6];
        int          n;
        int          ptr;
        int          cyc;
        longint      total;
        logic        acc;
        bit          abort;
        abort = 1'b0;
        for (int g = 0; g < 1000 && !abort; g++) begin
            n     = $urandom_range(1, 6);
            total = 0;
            for (int i = 0; i < n; i++) begin
                beats[i] = 16'($urandom);
                total   += beats[i];
            end
            ptr = 0;
            cyc = 0;
            while (ptr < n && cyc < 100) begin
                applyStimulus(($urandom_range(0, 9) < 7), beats[ptr], (ptr == n - 1),
                              1'($urandom));
                n_cmp++;
                if (obs_hs !== exp_hs(m_hold)) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_hs_acc g=%0d: got %b expected %b",
                             g, obs_hs, exp_hs(m_hold));
                end
                tick(acc);
                if (acc) ptr++;
                cyc++;
            end
            if (ptr < n || !m_hold) begin
                n_fail++;
                $display("[TB] FAIL rnd_feed_timeout g=%0d: got %0d beats taken expected %0d",
                         g, ptr, n);
                abort = 1'b1;
            end else begin
                cyc = 0;
                while (m_hold && cyc < 100) begin
                    n_cmp++;
                    if (obs_hs !== exp_hs(1'b1) || obs_all !== exp_all(total, n)) begin
                        n_fail++;
                        $display("[TB] FAIL rnd_result g=%0d: got %b/%h expected %b/%h",
                                 g, obs_hs, obs_all, exp_hs(1'b1), exp_all(total, n));
                    end
                    applyStimulus(1'($urandom), 16'($urandom), 1'($urandom),
                                  ($urandom_range(0, 9) < 5));
                    tick(acc);
                    cyc++;
                end
                if (m_hold) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_hold_timeout g=%0d: got still holding expected release", g);
                    abort = 1'b1;
                end else begin
                    n_cmp++;
                    if (obs_all !== exp_all(0, 0)) begin
                        n_fail++;
                        $display("[TB] FAIL rnd_cleared g=%0d: got %h expected %h",
                                 g, obs_all, exp_all(0, 0));
                    end
                end
            end
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        m_hold = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_count_sat();
        test_reset_mid();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
